demux_param_reg: RTL and testbench
==================================

Name: demux_param_reg

Overview:
- Registered, flow-controlled 1-to-SIZE demultiplexer: the distribution counterpart of the parameterised select-one-of-SIZE mux.
- Accepts one WIDTH-bit payload per cycle, tagged with a lane select, and steers it into a one-entry output register for that lane.
- Each lane has an independent valid/ready handshake.
- Used wherever a shared result bus fans out to per-lane consumers, such as per-wavefront or per-slot writeback.

Parameters:
- BITS, 2, width of in_select.
- SIZE, 4, number of output lanes; must be ≤ 2^BITS.
- WIDTH, 1, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  input  1  input payload present.
- in_ready  output  1  input accepted this cycle when in_valid && in_ready.
- in_data  input  WIDTH  payload.
- in_select  input  BITS  destination lane index.
- out_valid  output  SIZE  bit i = lane i holds data.
- out_ready  input  SIZE  bit i = lane i consumer takes data this cycle.
- out_data  output  SIZE*WIDTH  lane i data on bits [WIDTH*(i+1)-1 -: WIDTH].
- sel_err  output  1  sticky flag: an out-of-range select was accepted.
- drop_count  output  8  saturating count of dropped out-of-range payloads.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, sel_err=0, drop_count=0. This applies immediately, mid-transfer included; any held lane data is discarded.
- Lane state: each lane i is EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1). There is no other state.
- in_ready is combinational:
  - If in_select < SIZE: in_ready = ~out_valid[in_select] | out_ready[in_select].
  - If in_select ≥ SIZE: in_ready = 1.
  - in_ready must not depend on in_valid.
- Accept = in_valid && in_ready.
- Accept to an in-range lane s: at the next edge, out_data lane s = in_data and out_valid[s] = 1. Latency is exactly 1 cycle from accept to visibility.
- Drain: out_valid[i] && out_ready[i] with no new write to lane i → out_valid[i]=0 at the next edge. out_data lane i holds its last value and is not cleared.
- Simultaneous drain and write to the same lane: the lane stays FULL and takes the new data. Full throughput is one payload per cycle per lane, with no bubble.
- Writes to lane s and drains of any other lanes in the same cycle are independent.
- Hold: while out_valid[i] && !out_ready[i], out_data lane i is stable.
- Out-of-range accept (in_select ≥ SIZE):
  - No lane is modified.
  - sel_err is set to 1 and stays 1 until reset.
  - drop_count increments by 1 and saturates at 255.
- out_ready[i] while out_valid[i]=0 is ignored.
- in_data and in_select are don't-care when in_valid=0; state must not change.
- Only in_select bits are compared, with no width extension issues. With SIZE == 2^BITS, the out-of-range path is unreachable and sel_err stays 0.

Test Plan (BITS=2, SIZE=3, WIDTH=8 unless noted):
- Reset then idle: rst=0 for 2 cycles, then 1 → out_valid=3'b000, out_data=0, sel_err=0, drop_count=0, in_ready=1 for every in_select.
- Single transfer: in_valid=1, in_select=1, in_data=8'hA5 for one cycle, out_ready=0 → next cycle out_valid=3'b010, lane1 data=8'hA5. It holds for 5 cycles. With out_ready[1]=1 for one cycle, out_valid becomes 3'b000 the cycle after.
- Backpressure: lane 2 FULL and out_ready[2]=0, present in_select=2, in_data=8'h3C → in_ready=0 and lane 2 data unchanged. Raise out_ready[2] → in_ready=1 the same cycle, and next cycle lane 2=8'h3C with out_valid[2] still 1.
- Streaming: out_ready=3'b111, send 8'h01..8'h08 alternating lanes 0 and 1 back-to-back → in_ready=1 every cycle. Each payload appears on its lane exactly 1 cycle after accept, in order.
- Out-of-range: send in_select=3 three times → in_ready=1, no out_valid change, sel_err=1, drop_count=3. Send 300 such payloads → drop_count=255.
- Async reset mid-operation: lanes 0 and 2 FULL, drop_count=5; pull rst low between clock edges → out_valid=0 and drop_count=0 before the next edge.

Source files
------------

// File: rtl/demux_param_reg.sv
// Registered 1-to-SIZE demultiplexer with one output register per lane and an
// independent valid/ready handshake on each lane. Out-of-range selects are dropped and counted.
module demux_param_reg #(
  parameter int BITS  = 2,
  parameter int SIZE  = 4,
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [BITS-1:0]         in_select,
  output logic [SIZE-1:0]         out_valid,
  input  logic [SIZE-1:0]         out_ready,
  output logic [SIZE*WIDTH-1:0]   out_data,
  output logic                    sel_err,
  output logic [7:0]              drop_count
);

  logic [SIZE-1:0] lane_hit;
  logic            in_range;
  logic            accept;
  logic [SIZE-1:0] wr_lane;
  logic            drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One-hot decode of the select; an all-zero result means the select is past the last lane.
  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (in_select == BITS'(i)) lane_hit[i] = 1'b1;
    end
    in_range = |lane_hit;
    in_ready = ~in_range | (|(lane_hit & (~out_valid | out_ready)));
    accept   = in_valid & in_ready;
    wr_lane  = lane_hit & {SIZE{accept}};
    drop     = accept & ~in_range;
  end

  // Lane registers: a write wins over a drain so a full lane streams without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      sel_err    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (wr_lane[i]) begin
          out_valid[i]                <= 1'b1;
          out_data[i*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]                <= 1'b0;
        end
      end
      if (drop) begin
        sel_err    <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_demux_param_reg.sv
// Directed bench for demux_param_reg with BITS=2, SIZE=3, WIDTH=8 and hand-computed expectations.
module tb_demux_param_reg;
  localparam int BITS  = 2;
  localparam int SIZE  = 3;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [BITS-1:0]       in_select;
  logic [SIZE-1:0]       out_valid;
  logic [SIZE-1:0]       out_ready;
  logic [SIZE*WIDTH-1:0] out_data;
  logic                  sel_err;
  logic [7:0]            drop_count;

  int n_cmp = 0;
  int n_err = 0;

  demux_param_reg #(.BITS(BITS), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_select(in_select), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lane(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_select = '0; out_ready = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL reset_out_valid got %b want 000", out_valid); end
    n_cmp++; if (out_data !== 24'h0) begin n_err++; $display("FAIL reset_out_data got %h want 000000", out_data); end
    n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
    for (int s = 0; s < 4; s++) begin
      in_select = s[BITS-1:0];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready); end
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_select = 2'd1; in_data = 8'hA5; out_ready = 3'b000;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    n_cmp++; if (out_valid !== 3'b010) begin n_err++; $display("FAIL single_valid got %b want 010", out_valid); end
    n_cmp++; if (lane(1) !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", lane(1)); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out_valid !== 3'b010 || lane(1) !== 8'hA5) begin
        n_err++; $display("FAIL single_hold cyc=%0d got %b/%h want 010/a5", k, out_valid, lane(1));
      end
    end
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
    n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL single_drain got %b want 000", out_valid); end
    n_cmp++; if (lane(1) !== 8'hA5) begin n_err++; $display("FAIL single_data_kept got %h want a5", lane(1)); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_select = 2'd2; in_data = 8'h11; out_ready = 3'b000;
    tick();
    in_data = 8'h3C;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low got %b want 0", in_ready); end
    tick();
    n_cmp++; if (lane(2) !== 8'h11 || out_valid[2] !== 1'b1) begin
      n_err++; $display("FAIL bp_hold got %h/%b want 11/1", lane(2), out_valid[2]);
    end
    out_ready = 3'b100;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_high got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    n_cmp++; if (lane(2) !== 8'h3C || out_valid[2] !== 1'b1) begin
      n_err++; $display("FAIL bp_replace got %h/%b want 3c/1", lane(2), out_valid[2]);
    end
    out_ready = 3'b100;
    tick();
    out_ready = 3'b000;
    n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL bp_drain got %b want 000", out_valid); end
  endtask

  task automatic test_streaming();
    logic [SIZE-1:0] exp_v;
    out_ready = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_select = BITS'((k - 1) % 2); in_data = WIDTH'(k);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d got %b want 1", k, in_ready); end
      tick();
      exp_v = SIZE'(1) << ((k - 1) % 2);
      n_cmp++; if (out_valid !== exp_v || lane((k - 1) % 2) !== WIDTH'(k)) begin
        n_err++; $display("FAIL stream_data k=%0d got %b/%h want %b/%h", k, out_valid, lane((k - 1) % 2), exp_v, k);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 3'b000;
    n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL stream_empty got %b want 000", out_valid); end
  endtask

  task automatic test_out_of_range();
    in_valid = 1'b1; in_select = 2'd0; in_data = 8'h77; out_ready = 3'b000;
    tick();
    for (int k = 0; k < 3; k++) begin
      in_select = 2'd3; in_data = 8'hEE;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL oor_ready k=%0d got %b want 1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 3'b001 || lane(0) !== 8'h77) begin
      n_err++; $display("FAIL oor_lanes got %b/%h want 001/77", out_valid, lane(0));
    end
    n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL oor_sel_err got %b want 1", sel_err); end
    n_cmp++; if (drop_count !== 8'd3) begin n_err++; $display("FAIL oor_count3 got %0d want 3", drop_count); end
    in_data = 8'hFF; in_select = 2'd3;
    tick(); tick();
    n_cmp++; if (drop_count !== 8'd3 || out_valid !== 3'b001) begin
      n_err++; $display("FAIL idle_no_change got %0d/%b want 3/001", drop_count, out_valid);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    in_valid = 1'b0;
    n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL oor_saturate got %0d want 255", drop_count); end
    n_cmp++; if (sel_err !== 1'b1 || lane(0) !== 8'h77) begin
      n_err++; $display("FAIL oor_sticky got %b/%h want 1/77", sel_err, lane(0));
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b0; #2; rst = 1'b1;
    #1;
    n_cmp++; if (drop_count !== 8'd0 || out_valid !== 3'b000 || sel_err !== 1'b0) begin
      n_err++; $display("FAIL arst_clear got %0d/%b/%b want 0/000/0", drop_count, out_valid, sel_err);
    end
    tick();
    in_valid = 1'b1; in_select = 2'd0; in_data = 8'h5A;
    tick();
    in_select = 2'd2; in_data = 8'hC3;
    tick();
    in_select = 2'd3;
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 3'b101 || drop_count !== 8'd5 || lane(0) !== 8'h5A || lane(2) !== 8'hC3) begin
      n_err++; $display("FAIL arst_setup got %b/%0d/%h/%h want 101/5/5a/c3", out_valid, drop_count, lane(0), lane(2));
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 3'b000 || drop_count !== 8'd0) begin
      n_err++; $display("FAIL arst_mid got %b/%0d want 000/0", out_valid, drop_count);
    end
    n_cmp++; if (out_data !== 24'h0 || sel_err !== 1'b0) begin
      n_err++; $display("FAIL arst_mid_data got %h/%b want 000000/0", out_data, sel_err);
    end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_out_of_range();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
